// File: rtl/mult_fu_pkg.sv
// Shared types for the pipelined multiply unit: func encoding, stage/issue/CDB packets
// and the operand-extension / result-selection helpers.
package mult_fu_pkg;

    localparam int MULT_PREG_W   = 6;
    localparam int MULT_RS_IDX_W = 3;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic                     valid;
        logic [MULT_PREG_W-1:0]   dest_tag;
        logic [MULT_RS_IDX_W-1:0] rs_idx;
        MULT_FUNC                 func;
        logic [63:0]              prod;
        logic [63:0]              mcand;
        logic [63:0]              mplier;
    } MULT_STAGE_PACKET;

    typedef struct packed {
        logic [MULT_RS_IDX_W-1:0] rs_idx;
        logic [MULT_PREG_W-1:0]   dest_tag;
        MULT_FUNC                 func;
        logic [31:0]              rs1_val;
        logic [31:0]              rs2_val;
    } MULT_ISSUE_PACKET;

    typedef struct packed {
        logic [MULT_PREG_W-1:0] tag;
        logic [31:0]            value;
    } MULT_CDB_PACKET;

    // rs1 is signed for every func except MULHU; rs2 only for MUL/MULH.
    function automatic MULT_STAGE_PACKET mult_init(input MULT_ISSUE_PACKET ip);
        MULT_STAGE_PACKET p;
        logic             rs1_signed;
        logic             rs2_signed;
        rs1_signed = (ip.func != MULHU);
        rs2_signed = (ip.func == MUL) || (ip.func == MULH);
        p.valid    = 1'b1;
        p.dest_tag = ip.dest_tag;
        p.rs_idx   = ip.rs_idx;
        p.func     = ip.func;
        p.prod     = '0;
        p.mcand    = {{32{rs1_signed & ip.rs1_val[31]}}, ip.rs1_val};
        p.mplier   = {{32{rs2_signed & ip.rs2_val[31]}}, ip.rs2_val};
        return p;
    endfunction

    function automatic logic [31:0] mult_result(input MULT_STAGE_PACKET p);
        return (p.func == MUL) ? p.prod[31:0] : p.prod[63:32];
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One partial-product step: adds mcand times the low C multiplier bits, then shifts
// both operands by C so the next stage sees the next multiplier slice.
module mult_stage
    import mult_fu_pkg::*;
#(
    parameter int C = 16
) (
    input  MULT_STAGE_PACKET pkt_in,
    output MULT_STAGE_PACKET pkt_out
);

    always_comb begin
        pkt_out        = pkt_in;
        pkt_out.prod   = pkt_in.prod + pkt_in.mcand * {{(64-C){1'b0}}, pkt_in.mplier[C-1:0]};
        pkt_out.mcand  = pkt_in.mcand << C;
        pkt_out.mplier = pkt_in.mplier >> C;
    end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit with collapsing bubbles, CDB hold and squash flush.
// Optional performance counters are built when MULT_FU_PERF_EN is defined.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int PREG_W     = MULT_PREG_W,
    parameter int RS_IDX_W   = MULT_RS_IDX_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [RS_IDX_W-1:0] issue_rs_idx,
    input  logic [PREG_W-1:0]   issue_dest_tag,
    input  logic [1:0]          issue_func,
    input  logic [31:0]         issue_rs1_val,
    input  logic [31:0]         issue_rs2_val,
    input  logic                squash,
    output logic                cdb_req,
    input  logic                cdb_grant,
    output logic [PREG_W-1:0]   cdb_tag,
    output logic [31:0]         cdb_value,
    output logic                rs_remove_en,
    output logic [RS_IDX_W-1:0] rs_remove_idx,
    output logic                busy
`ifdef MULT_FU_PERF_EN
    ,
    output logic [31:0]         perf_ops_done,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int C    = 64 / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;

    MULT_ISSUE_PACKET issue_pkt;
    MULT_CDB_PACKET   cdb_pkt;
    MULT_STAGE_PACKET stage_reg [NUM_STAGES];
    MULT_STAGE_PACKET stage_in  [NUM_STAGES];
    MULT_STAGE_PACKET stage_out [NUM_STAGES];

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] advance;
    logic                  accept;
    logic                  rs_remove_en_reg;
    logic [RS_IDX_W-1:0]   rs_remove_idx_reg;

    assign issue_pkt.rs_idx   = issue_rs_idx;
    assign issue_pkt.dest_tag = issue_dest_tag;
    assign issue_pkt.func     = MULT_FUNC'(issue_func);
    assign issue_pkt.rs1_val  = issue_rs1_val;
    assign issue_pkt.rs2_val  = issue_rs2_val;

    // Advance ripples back from the tail: a stage moves if its successor is empty or moving.
    always_comb begin
        advance       = '0;
        advance[LAST] = valid[LAST] && cdb_grant;
        for (int k = LAST - 1; k >= 0; k--) begin
            advance[k] = valid[k] && (!valid[k+1] || advance[k+1]);
        end
    end

    assign issue_ready = !valid[0] || advance[0];
    assign accept      = issue_valid && issue_ready && !squash;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic load;

            if (gi == 0) begin : g_head
                assign stage_in[gi] = mult_init(issue_pkt);
                assign load         = accept;
            end else begin : g_body
                assign stage_in[gi] = stage_reg[gi-1];
                assign load         = advance[gi-1];
            end

            mult_stage #(.C(C)) u_stage (
                .pkt_in  (stage_in[gi]),
                .pkt_out (stage_out[gi])
            );

            always_ff @(posedge clock) begin
                if (reset) begin
                    stage_reg[gi] <= '0;
                end else if (squash) begin
                    stage_reg[gi].valid <= 1'b0;
                end else if (load) begin
                    stage_reg[gi]       <= stage_out[gi];
                    stage_reg[gi].valid <= 1'b1;
                end else if (advance[gi]) begin
                    stage_reg[gi].valid <= 1'b0;
                end
            end

            assign valid[gi] = stage_reg[gi].valid;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rs_remove_en_reg  <= 1'b0;
            rs_remove_idx_reg <= '0;
        end else begin
            rs_remove_en_reg <= accept;
            if (accept) begin
                rs_remove_idx_reg <= issue_rs_idx;
            end
        end
    end

    assign cdb_pkt.tag   = stage_reg[LAST].dest_tag;
    assign cdb_pkt.value = mult_result(stage_reg[LAST]);

    assign cdb_req       = valid[LAST];
    assign cdb_tag       = cdb_pkt.tag;
    assign cdb_value     = cdb_pkt.value;
    assign rs_remove_en  = rs_remove_en_reg;
    assign rs_remove_idx = rs_remove_idx_reg;
    assign busy          = |valid;

    // The tail's operand shifters and RS index have no consumer.
    logic unused_tail;
    assign unused_tail = ^{stage_reg[LAST].rs_idx, stage_reg[LAST].mcand, stage_reg[LAST].mplier};

`ifdef MULT_FU_PERF_EN
    logic [31:0] perf_ops_done_reg;
    logic [31:0] perf_stall_cycles_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops_done_reg     <= '0;
            perf_stall_cycles_reg <= '0;
        end else begin
            if (cdb_req && cdb_grant && !squash) begin
                perf_ops_done_reg <= perf_ops_done_reg + 32'd1;
            end
            if (cdb_req && !cdb_grant) begin
                perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_ops_done     = perf_ops_done_reg;
    assign perf_stall_cycles = perf_stall_cycles_reg;
`endif

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: reset, latency, funcs, full-pipe backpressure, bubble
// collapse and squash.
module tb_mult_fu;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_rs_idx;
    logic [5:0]  issue_dest_tag;
    logic [1:0]  issue_func;
    logic [31:0] issue_rs1_val;
    logic [31:0] issue_rs2_val;
    logic        squash;
    logic        cdb_req;
    logic        cdb_grant;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        rs_remove_en;
    logic [2:0]  rs_remove_idx;
    logic        busy;
`ifdef MULT_FU_PERF_EN
    logic [31:0] perf_ops_done;
    logic [31:0] perf_stall_cycles;
`endif

    int tests_run;
    int tests_failed;

    mult_fu dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs_idx   (issue_rs_idx),
        .issue_dest_tag (issue_dest_tag),
        .issue_func     (issue_func),
        .issue_rs1_val  (issue_rs1_val),
        .issue_rs2_val  (issue_rs2_val),
        .squash         (squash),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .rs_remove_en   (rs_remove_en),
        .rs_remove_idx  (rs_remove_idx),
        .busy           (busy)
`ifdef MULT_FU_PERF_EN
        ,
        .perf_ops_done     (perf_ops_done),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input logic [5:0] tag, input logic [2:0] idx, input logic [1:0] fn,
                             input logic [31:0] a, input logic [31:0] b);
        issue_valid    = 1'b1;
        issue_dest_tag = tag;
        issue_rs_idx   = idx;
        issue_func     = fn;
        issue_rs1_val  = a;
        issue_rs2_val  = b;
        $display("[TB] issue tag=%0d idx=%0d func=%0d rs1=%h rs2=%h", tag, idx, fn, a, b);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        tests_run++;
        if (cdb_req !== 1'b0) begin tests_failed++; $display("FAIL reset_cdb_req: got %0b want 0", cdb_req); end
        tests_run++;
        if (rs_remove_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rs_remove_en: got %0b want 0", rs_remove_en); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
        tests_run++;
        if (cdb_tag !== 6'd0 || cdb_value !== 32'd0 || rs_remove_idx !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tag=%0d value=%h idx=%0d want 0/0/0", cdb_tag, cdb_value, rs_remove_idx);
        end
        $display("[TB] reset released");
        reset = 1'b0;
        step();
    endtask

    task automatic test_mul_latency();
        cdb_grant = 1'b1;
        set_issue(6'd5, 3'd3, 2'd0, 32'd7, 32'hFFFF_FFFD);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL lat_ready: got %0b want 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        #1;
        tests_run++;
        if (rs_remove_en !== 1'b1 || rs_remove_idx !== 3'd3) begin
            tests_failed++;
            $display("FAIL lat_remove: got en=%0b idx=%0d want 1/3", rs_remove_en, rs_remove_idx);
        end
        for (int t = 1; t <= 4; t++) begin
            if (t != 1) step();
            tests_run++;
            if (cdb_req !== (t == 4)) begin
                tests_failed++;
                $display("FAIL lat_req_c%0d: got %0b want %0b", t, cdb_req, (t == 4));
            end
            if (t == 2) begin
                tests_run++;
                if (rs_remove_en !== 1'b0) begin tests_failed++; $display("FAIL lat_remove_pulse: got %0b want 0", rs_remove_en); end
            end
        end
        tests_run++;
        if (cdb_tag !== 6'd5 || cdb_value !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL lat_result: got tag=%0d value=%h want 5/ffffffeb", cdb_tag, cdb_value);
        end
        $display("[TB] result tag=%0d value=%h", cdb_tag, cdb_value);
        step();
        tests_run++;
        if (busy !== 1'b0 || cdb_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_drain: got busy=%0b req=%0b want 0/0", busy, cdb_req);
        end
    endtask

    task automatic test_funcs();
        logic [1:0]  fn  [4];
        logic [31:0] exp [4];
        fn[0] = 2'd1; exp[0] = 32'h0000_0000;
        fn[1] = 2'd3; exp[1] = 32'hFFFF_FFFE;
        fn[2] = 2'd2; exp[2] = 32'hFFFF_FFFF;
        fn[3] = 2'd0; exp[3] = 32'h0000_0001;
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_issue(6'(i + 1), 3'(i), fn[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            step();
        end
        issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (cdb_req !== 1'b1 || cdb_tag !== 6'(i + 1) || cdb_value !== exp[i]) begin
                tests_failed++;
                $display("FAIL func_%0d: got req=%0b tag=%0d value=%h want 1/%0d/%h",
                         fn[i], cdb_req, cdb_tag, cdb_value, i + 1, exp[i]);
            end
            $display("[TB] result tag=%0d value=%h", cdb_tag, cdb_value);
            step();
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL func_drain: got busy=%0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        cdb_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_issue(6'(10 + i), 3'(i), 2'd0, 32'(i + 2), 32'd10);
            #1;
            tests_run++;
            if (issue_ready !== (i < 4)) begin
                tests_failed++;
                $display("FAIL full_ready_%0d: got %0b want %0b", i, issue_ready, (i < 4));
            end
            if (i < 4) step();
        end
        for (int h = 0; h < 3; h++) begin
            #1;
            tests_run++;
            if (issue_ready !== 1'b0 || cdb_req !== 1'b1 || cdb_tag !== 6'd10 || cdb_value !== 32'd20) begin
                tests_failed++;
                $display("FAIL full_hold_%0d: got ready=%0b req=%0b tag=%0d value=%h want 0/1/10/00000014",
                         h, issue_ready, cdb_req, cdb_tag, cdb_value);
            end
            if (h == 1) begin
                tests_run++;
                if (rs_remove_en !== 1'b0) begin tests_failed++; $display("FAIL full_no_remove: got %0b want 0", rs_remove_en); end
            end
            step();
        end
        cdb_grant = 1'b1;
        for (int r = 0; r < 5; r++) begin
            #1;
            if (r == 0) begin
                tests_run++;
                if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL full_grant_ready: got %0b want 1", issue_ready); end
            end
            tests_run++;
            if (cdb_req !== 1'b1 || cdb_tag !== 6'(10 + r) || cdb_value !== 32'((r + 2) * 10)) begin
                tests_failed++;
                $display("FAIL full_order_%0d: got req=%0b tag=%0d value=%h want 1/%0d/%h",
                         r, cdb_req, cdb_tag, cdb_value, 10 + r, (r + 2) * 10);
            end
            $display("[TB] result tag=%0d value=%h", cdb_tag, cdb_value);
            step();
            if (r == 0) begin
                issue_valid = 1'b0;
                #1;
                tests_run++;
                if (rs_remove_en !== 1'b1 || rs_remove_idx !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL full_accept5: got en=%0b idx=%0d want 1/4", rs_remove_en, rs_remove_idx);
                end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_drain: got busy=%0b want 0", busy); end
    endtask

    task automatic test_bubble();
        cdb_grant = 1'b0;
        set_issue(6'd20, 3'd1, 2'd0, 32'd3, 32'd4);
        step();
        issue_valid = 1'b0;
        step();
        step();
        set_issue(6'd21, 3'd2, 2'd0, 32'd5, 32'd6);
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        cdb_grant = 1'b1;
        #1;
        tests_run++;
        if (cdb_req !== 1'b1 || cdb_tag !== 6'd20 || cdb_value !== 32'd12) begin
            tests_failed++;
            $display("FAIL bubble_a: got req=%0b tag=%0d value=%h want 1/20/0000000c", cdb_req, cdb_tag, cdb_value);
        end
        $display("[TB] result tag=%0d value=%h", cdb_tag, cdb_value);
        step();
        tests_run++;
        if (cdb_req !== 1'b1 || cdb_tag !== 6'd21 || cdb_value !== 32'd30) begin
            tests_failed++;
            $display("FAIL bubble_b: got req=%0b tag=%0d value=%h want 1/21/0000001e", cdb_req, cdb_tag, cdb_value);
        end
        $display("[TB] result tag=%0d value=%h", cdb_tag, cdb_value);
        step();
        tests_run++;
        if (cdb_req !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_drain: got req=%0b busy=%0b want 0/0", cdb_req, busy);
        end
    endtask

    task automatic test_squash();
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_issue(6'(30 + i), 3'(i), 2'd0, 32'd9, 32'd9);
            step();
        end
        set_issue(6'd33, 3'd5, 2'd0, 32'd9, 32'd9);
        squash = 1'b1;
        $display("[TB] squash");
        step();
        squash      = 1'b0;
        issue_valid = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || cdb_req !== 1'b0 || rs_remove_en !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL squash_flush: got busy=%0b req=%0b remove=%0b ready=%0b want 0/0/0/1",
                     busy, cdb_req, rs_remove_en, issue_ready);
        end
        cdb_grant = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            tests_run++;
            if (cdb_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL squash_ghost_%0d: got req=%0b tag=%0d want req 0", c, cdb_req, cdb_tag);
            end
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        issue_valid    = 1'b0;
        issue_rs_idx   = '0;
        issue_dest_tag = '0;
        issue_func     = '0;
        issue_rs1_val  = '0;
        issue_rs2_val  = '0;
        squash         = 1'b0;
        cdb_grant      = 1'b0;
        #1;
        test_reset();
        test_mul_latency();
        test_funcs();
        test_back_to_back();
        test_bubble();
        test_squash();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit that consumes ops issued from the reservation station's mult entries.
- Sign-extends operands per RV32M func, accumulates partial products over NUM_STAGES stages, and holds the result in the tail stage until the CDB arbiter grants.
- Returns a remove request to the RS for each accepted op. Bubbles collapse; squash (interrupt/recovery) flushes all in-flight ops.

Parameters:
- NUM_STAGES, 4, pipeline depth; must divide 64 (each stage consumes 64/NUM_STAGES multiplier bits)
- PREG_W, 6, physical register tag width
- RS_IDX_W, 3, RS entry index width (5-entry RS)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  RS presents a mult op
- issue_ready  out  1  stage 0 can accept this cycle
- issue_rs_idx  in  RS_IDX_W  RS entry holding the op
- issue_dest_tag  in  PREG_W  destination physical register
- issue_func  in  2  MULT_FUNC: MUL=0, MULH=1, MULHSU=2, MULHU=3
- issue_rs1_val  in  32  multiplicand operand
- issue_rs2_val  in  32  multiplier operand
- squash  in  1  flush all in-flight ops (interrupt/mispredict)
- cdb_req  out  1  tail stage holds a finished result
- cdb_grant  in  1  arbiter grants CDB this cycle
- cdb_tag  out  PREG_W  dest tag of tail result
- cdb_value  out  32  tail result value
- rs_remove_en  out  1  free RS entry (registered)
- rs_remove_idx  out  RS_IDX_W  entry to free
- busy  out  1  any stage valid

Behaviour:
- Reset values: all stage valid bits = 0; cdb_req, rs_remove_en, busy = 0; cdb_tag, cdb_value, rs_remove_idx = 0; issue_ready = 1 (combinational).
- Operand extension to 64 bits:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
- Stage k: prod += mcand * mplier[C-1:0]; mcand <<= C; mplier >>= C, where C = 64/NUM_STAGES. All arithmetic is mod 2^64.
- Result selection: MUL returns prod[31:0]; all other funcs return prod[63:32]. Selection is combinational from the tail stage.
- advance[last] = valid[last] && cdb_grant.
- advance[k] = valid[k] && (!valid[k+1] || advance[k+1]).
- A stage whose successor is empty always moves, so bubbles collapse.
- issue_ready = !valid[0] || advance[0]. Accept = issue_valid && issue_ready && !squash.
- Latency: op accepted in cycle 0 gives cdb_req = 1 in cycle NUM_STAGES when the pipe is uncontended.
- cdb_req = valid[last]. cdb_tag and cdb_value stay stable while cdb_req && !cdb_grant.
- cdb_grant while cdb_req = 0 is ignored.
- rs_remove_en is 1 for exactly one cycle, the cycle after an accept; rs_remove_idx is the accepted issue_rs_idx.
- Squash has priority over everything:
  - all valid bits clear at the next edge;
  - a same-cycle issue is not accepted;
  - a same-cycle grant does not count as a broadcast;
  - the pending rs_remove_en is cleared to 0 at the next edge.
- Full condition: all NUM_STAGES stages valid and no grant → issue_ready = 0. Max in flight = NUM_STAGES.
- Full pipe with grant: retire and accept occur in the same cycle (throughput 1/cycle).
- Reset mid-operation behaves identically to squash, plus the output register clears.

Optional Feature:
- Macro: MULT_FU_PERF_EN.
- Defined: adds output ports perf_ops_done[31:0] (count of granted broadcasts) and perf_stall_cycles[31:0] (count of cycles with cdb_req && !cdb_grant).
  - Both counters are reset to 0, wrap at 2^32, and are not affected by squash.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- sys_defs.svh:
  - MULT_FUNC enum;
  - MULT_STAGE_PACKET struct {valid, dest_tag, rs_idx, func, prod[63:0], mcand[63:0], mplier[63:0]};
  - MULT_ISSUE_PACKET and MULT_CDB_PACKET bundling the issue and CDB fields for top-level wiring.
- Sub-module mult_stage: combinational single partial-product step (packet in → packet out), instantiated NUM_STAGES times. mult_fu owns the valid/advance control and the registers.

Test Plan:
- Reset held 2 cycles → cdb_req = 0, rs_remove_en = 0, busy = 0, issue_ready = 1.
- MUL rs1 = 7, rs2 = 0xFFFFFFFD, tag 5, rs_idx 3, issued cycle 0, grant tied 1 → rs_remove_en = 1 / idx 3 in cycle 1; cdb_req in cycle 4 with tag 5 and value 0xFFFFFFEB.
- Operands 0xFFFFFFFF × 0xFFFFFFFF → MULH = 0x00000000, MULHU = 0xFFFFFFFE, MULHSU = 0xFFFFFFFF, MUL = 0x00000001.
- Grant = 0, issue 5 ops back-to-back:
  - the 5th sees issue_ready = 0 once 4 are in flight;
  - cdb_value holds op0 steady;
  - raising grant returns results in issue order, one per cycle, and the 5th is accepted in the first grant cycle.
- Op A issued, 2 idle cycles, op B issued, grant = 0 → B collapses to stage NUM_STAGES-2 directly behind A; no gap remains.
- 3 ops in flight plus issue_valid and squash in the same cycle → next cycle busy = 0, cdb_req = 0, rs_remove_en = 0, issue_ready = 1; no later broadcast of the squashed tags.
